// File: rtl/second_part_lut_if.sv
// Operand/result bundle for the squaring lookup block.
// The master drives the operand; the slave returns the registered upper byte of its square.
interface second_part_lut_if;
  logic [7:0] inp;
  logic [7:0] out;

  modport master (output inp, input out);
  modport slave  (input inp, output out);
endinterface

// File: rtl/second_part_lut.sv
// Registered upper byte of an 8-bit square, out = floor(inp*inp / 256), from a 256-entry constant table.
// One result per cycle, one cycle of latency, synchronous active-high reset clears the output.
module second_part_lut (
  input  logic             clk,
  input  logic             rst,
  second_part_lut_if.slave bus
);

  logic [7:0] lut_val;

  // Table entries for 128..255 follow f(128+d) = 64 + d + f(d), which makes spot checks easy.
  always_comb begin
    // NOTE: a default before the case guarantees every path assigns lut_val, so no latch is inferred.
    lut_val = 8'd0;
    case (bus.inp)
      8'd0:   lut_val = 8'd0;    8'd1:   lut_val = 8'd0;    8'd2:   lut_val = 8'd0;    8'd3:   lut_val = 8'd0;
      8'd4:   lut_val = 8'd0;    8'd5:   lut_val = 8'd0;    8'd6:   lut_val = 8'd0;    8'd7:   lut_val = 8'd0;
      8'd8:   lut_val = 8'd0;    8'd9:   lut_val = 8'd0;    8'd10:  lut_val = 8'd0;    8'd11:  lut_val = 8'd0;
      8'd12:  lut_val = 8'd0;    8'd13:  lut_val = 8'd0;    8'd14:  lut_val = 8'd0;    8'd15:  lut_val = 8'd0;
      8'd16:  lut_val = 8'd1;    8'd17:  lut_val = 8'd1;    8'd18:  lut_val = 8'd1;    8'd19:  lut_val = 8'd1;
      8'd20:  lut_val = 8'd1;    8'd21:  lut_val = 8'd1;    8'd22:  lut_val = 8'd1;    8'd23:  lut_val = 8'd2;
      8'd24:  lut_val = 8'd2;    8'd25:  lut_val = 8'd2;    8'd26:  lut_val = 8'd2;    8'd27:  lut_val = 8'd2;
      8'd28:  lut_val = 8'd3;    8'd29:  lut_val = 8'd3;    8'd30:  lut_val = 8'd3;    8'd31:  lut_val = 8'd3;
      8'd32:  lut_val = 8'd4;    8'd33:  lut_val = 8'd4;    8'd34:  lut_val = 8'd4;    8'd35:  lut_val = 8'd4;
      8'd36:  lut_val = 8'd5;    8'd37:  lut_val = 8'd5;    8'd38:  lut_val = 8'd5;    8'd39:  lut_val = 8'd5;
      8'd40:  lut_val = 8'd6;    8'd41:  lut_val = 8'd6;    8'd42:  lut_val = 8'd6;    8'd43:  lut_val = 8'd7;
      8'd44:  lut_val = 8'd7;    8'd45:  lut_val = 8'd7;    8'd46:  lut_val = 8'd8;    8'd47:  lut_val = 8'd8;
      8'd48:  lut_val = 8'd9;    8'd49:  lut_val = 8'd9;    8'd50:  lut_val = 8'd9;    8'd51:  lut_val = 8'd10;
      8'd52:  lut_val = 8'd10;   8'd53:  lut_val = 8'd10;   8'd54:  lut_val = 8'd11;   8'd55:  lut_val = 8'd11;
      8'd56:  lut_val = 8'd12;   8'd57:  lut_val = 8'd12;   8'd58:  lut_val = 8'd13;   8'd59:  lut_val = 8'd13;
      8'd60:  lut_val = 8'd14;   8'd61:  lut_val = 8'd14;   8'd62:  lut_val = 8'd15;   8'd63:  lut_val = 8'd15;
      8'd64:  lut_val = 8'd16;   8'd65:  lut_val = 8'd16;   8'd66:  lut_val = 8'd17;   8'd67:  lut_val = 8'd17;
      8'd68:  lut_val = 8'd18;   8'd69:  lut_val = 8'd18;   8'd70:  lut_val = 8'd19;   8'd71:  lut_val = 8'd19;
      8'd72:  lut_val = 8'd20;   8'd73:  lut_val = 8'd20;   8'd74:  lut_val = 8'd21;   8'd75:  lut_val = 8'd21;
      8'd76:  lut_val = 8'd22;   8'd77:  lut_val = 8'd23;   8'd78:  lut_val = 8'd23;   8'd79:  lut_val = 8'd24;
      8'd80:  lut_val = 8'd25;   8'd81:  lut_val = 8'd25;   8'd82:  lut_val = 8'd26;   8'd83:  lut_val = 8'd26;
      8'd84:  lut_val = 8'd27;   8'd85:  lut_val = 8'd28;   8'd86:  lut_val = 8'd28;   8'd87:  lut_val = 8'd29;
      8'd88:  lut_val = 8'd30;   8'd89:  lut_val = 8'd30;   8'd90:  lut_val = 8'd31;   8'd91:  lut_val = 8'd32;
      8'd92:  lut_val = 8'd33;   8'd93:  lut_val = 8'd33;   8'd94:  lut_val = 8'd34;   8'd95:  lut_val = 8'd35;
      8'd96:  lut_val = 8'd36;   8'd97:  lut_val = 8'd36;   8'd98:  lut_val = 8'd37;   8'd99:  lut_val = 8'd38;
      8'd100: lut_val = 8'd39;   8'd101: lut_val = 8'd39;   8'd102: lut_val = 8'd40;   8'd103: lut_val = 8'd41;
      8'd104: lut_val = 8'd42;   8'd105: lut_val = 8'd43;   8'd106: lut_val = 8'd43;   8'd107: lut_val = 8'd44;
      8'd108: lut_val = 8'd45;   8'd109: lut_val = 8'd46;   8'd110: lut_val = 8'd47;   8'd111: lut_val = 8'd48;
      8'd112: lut_val = 8'd49;   8'd113: lut_val = 8'd49;   8'd114: lut_val = 8'd50;   8'd115: lut_val = 8'd51;
      8'd116: lut_val = 8'd52;   8'd117: lut_val = 8'd53;   8'd118: lut_val = 8'd54;   8'd119: lut_val = 8'd55;
      8'd120: lut_val = 8'd56;   8'd121: lut_val = 8'd57;   8'd122: lut_val = 8'd58;   8'd123: lut_val = 8'd59;
      8'd124: lut_val = 8'd60;   8'd125: lut_val = 8'd61;   8'd126: lut_val = 8'd62;   8'd127: lut_val = 8'd63;
      8'd128: lut_val = 8'd64;   8'd129: lut_val = 8'd65;   8'd130: lut_val = 8'd66;   8'd131: lut_val = 8'd67;
      8'd132: lut_val = 8'd68;   8'd133: lut_val = 8'd69;   8'd134: lut_val = 8'd70;   8'd135: lut_val = 8'd71;
      8'd136: lut_val = 8'd72;   8'd137: lut_val = 8'd73;   8'd138: lut_val = 8'd74;   8'd139: lut_val = 8'd75;
      8'd140: lut_val = 8'd76;   8'd141: lut_val = 8'd77;   8'd142: lut_val = 8'd78;   8'd143: lut_val = 8'd79;
      8'd144: lut_val = 8'd81;   8'd145: lut_val = 8'd82;   8'd146: lut_val = 8'd83;   8'd147: lut_val = 8'd84;
      8'd148: lut_val = 8'd85;   8'd149: lut_val = 8'd86;   8'd150: lut_val = 8'd87;   8'd151: lut_val = 8'd89;
      8'd152: lut_val = 8'd90;   8'd153: lut_val = 8'd91;   8'd154: lut_val = 8'd92;   8'd155: lut_val = 8'd93;
      8'd156: lut_val = 8'd95;   8'd157: lut_val = 8'd96;   8'd158: lut_val = 8'd97;   8'd159: lut_val = 8'd98;
      8'd160: lut_val = 8'd100;  8'd161: lut_val = 8'd101;  8'd162: lut_val = 8'd102;  8'd163: lut_val = 8'd103;
      8'd164: lut_val = 8'd105;  8'd165: lut_val = 8'd106;  8'd166: lut_val = 8'd107;  8'd167: lut_val = 8'd108;
      8'd168: lut_val = 8'd110;  8'd169: lut_val = 8'd111;  8'd170: lut_val = 8'd112;  8'd171: lut_val = 8'd114;
      8'd172: lut_val = 8'd115;  8'd173: lut_val = 8'd116;  8'd174: lut_val = 8'd118;  8'd175: lut_val = 8'd119;
      8'd176: lut_val = 8'd121;  8'd177: lut_val = 8'd122;  8'd178: lut_val = 8'd123;  8'd179: lut_val = 8'd125;
      8'd180: lut_val = 8'd126;  8'd181: lut_val = 8'd127;  8'd182: lut_val = 8'd129;  8'd183: lut_val = 8'd130;
      8'd184: lut_val = 8'd132;  8'd185: lut_val = 8'd133;  8'd186: lut_val = 8'd135;  8'd187: lut_val = 8'd136;
      8'd188: lut_val = 8'd138;  8'd189: lut_val = 8'd139;  8'd190: lut_val = 8'd141;  8'd191: lut_val = 8'd142;
      8'd192: lut_val = 8'd144;  8'd193: lut_val = 8'd145;  8'd194: lut_val = 8'd147;  8'd195: lut_val = 8'd148;
      8'd196: lut_val = 8'd150;  8'd197: lut_val = 8'd151;  8'd198: lut_val = 8'd153;  8'd199: lut_val = 8'd154;
      8'd200: lut_val = 8'd156;  8'd201: lut_val = 8'd157;  8'd202: lut_val = 8'd159;  8'd203: lut_val = 8'd160;
      8'd204: lut_val = 8'd162;  8'd205: lut_val = 8'd164;  8'd206: lut_val = 8'd165;  8'd207: lut_val = 8'd167;
      8'd208: lut_val = 8'd169;  8'd209: lut_val = 8'd170;  8'd210: lut_val = 8'd172;  8'd211: lut_val = 8'd173;
      8'd212: lut_val = 8'd175;  8'd213: lut_val = 8'd177;  8'd214: lut_val = 8'd178;  8'd215: lut_val = 8'd180;
      8'd216: lut_val = 8'd182;  8'd217: lut_val = 8'd183;  8'd218: lut_val = 8'd185;  8'd219: lut_val = 8'd187;
      8'd220: lut_val = 8'd189;  8'd221: lut_val = 8'd190;  8'd222: lut_val = 8'd192;  8'd223: lut_val = 8'd194;
      8'd224: lut_val = 8'd196;  8'd225: lut_val = 8'd197;  8'd226: lut_val = 8'd199;  8'd227: lut_val = 8'd201;
      8'd228: lut_val = 8'd203;  8'd229: lut_val = 8'd204;  8'd230: lut_val = 8'd206;  8'd231: lut_val = 8'd208;
      8'd232: lut_val = 8'd210;  8'd233: lut_val = 8'd212;  8'd234: lut_val = 8'd213;  8'd235: lut_val = 8'd215;
      8'd236: lut_val = 8'd217;  8'd237: lut_val = 8'd219;  8'd238: lut_val = 8'd221;  8'd239: lut_val = 8'd223;
      8'd240: lut_val = 8'd225;  8'd241: lut_val = 8'd226;  8'd242: lut_val = 8'd228;  8'd243: lut_val = 8'd230;
      8'd244: lut_val = 8'd232;  8'd245: lut_val = 8'd234;  8'd246: lut_val = 8'd236;  8'd247: lut_val = 8'd238;
      8'd248: lut_val = 8'd240;  8'd249: lut_val = 8'd242;  8'd250: lut_val = 8'd244;  8'd251: lut_val = 8'd246;
      8'd252: lut_val = 8'd248;  8'd253: lut_val = 8'd250;  8'd254: lut_val = 8'd252;  8'd255: lut_val = 8'd254;
      default: lut_val = 8'd0;
    endcase
  end

  // The table is pure combinational constants; only the output register needs a reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      bus.out <= 8'd0;
    end else begin
      bus.out <= lut_val;
    end
  end

endmodule

// File: tb/tb_second_part_lut.sv
// Scoreboarded bench for second_part_lut: a driver queues expected results from an arithmetic model,
// and an independent monitor pops and compares them one edge later.
module tb_second_part_lut;

  logic clk;
  logic rst;
  second_part_lut_if bus ();

  second_part_lut dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q [$];
  int         kind_q [$];   // 0 = plain, 1 = sweep (also checked for monotonicity)
  logic [7:0] inp_q [$];

  logic [7:0] last_exp;
  bit         have_last = 1'b0;
  bit         monitor_on = 1'b1;

  function automatic logic [7:0] ref_f(input logic [7:0] x);
    int sq;
    sq = int'(x) * int'(x);
    return 8'(sq / 256);
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  // One cycle of stimulus; optional junk on inp mid-cycle must not reach out.
  task automatic step(input bit r, input logic [7:0] v, input int kind, input bit junk);
    if (junk) begin
      @(posedge clk);
      #3;
      bus.inp = 8'($urandom);
    end
    @(negedge clk);
    rst     = r;
    bus.inp = v;
    exp_q.push_back(r ? 8'd0 : ref_f(v));
    kind_q.push_back(kind);
    inp_q.push_back(v);
  endtask

  // Monitor: compare one edge after each issued vector, then confirm out holds until the next edge.
  initial begin
    logic [7:0] e;
    logic [7:0] prev_out;
    int         k;
    logic [7:0] v;
    bit         prev_sweep = 1'b0;
    while (monitor_on) begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        k = kind_q.pop_front();
        v = inp_q.pop_front();
        check($sformatf("out inp=0x%02h", v), bus.out, e);
        if (k == 1 && prev_sweep && bus.out < prev_out) begin
          total++;
          bad++;
          $display("FAIL monotonic inp=0x%02h: got 0x%02h after 0x%02h", v, bus.out, prev_out);
        end else if (k == 1 && prev_sweep) begin
          total++;
        end
        prev_sweep = (k == 1);
        prev_out   = bus.out;
        last_exp   = e;
        have_last  = 1'b1;
      end
      #3;
      if (have_last) check("stable mid-cycle", bus.out, last_exp);
    end
  end

  initial begin
    logic [7:0] stored [20];
    rst     = 1'b1;
    bus.inp = 8'hFF;

    // Reset held two edges with inp=0xFF, then release.
    step(1'b1, 8'hFF, 0, 1'b0);
    step(1'b1, 8'hFF, 0, 1'b0);
    step(1'b0, 8'hFF, 0, 1'b0);

    // Directed values and the 127 -> 129 gap.
    step(1'b0, 8'h00, 0, 1'b0);
    step(1'b0, 8'h0F, 0, 1'b0);
    step(1'b0, 8'h10, 0, 1'b0);
    step(1'b0, 8'h80, 0, 1'b0);
    step(1'b0, 8'hC0, 0, 1'b0);
    step(1'b0, 8'hFF, 0, 1'b0);
    step(1'b0, 8'hB5, 0, 1'b0);
    step(1'b0, 8'hB6, 0, 1'b0);

    // Exhaustive sweep with monotonicity.
    for (int i = 0; i < 256; i++) step(1'b0, 8'(i), 1, 1'b0);

    // Mid-stream reset discards the pending result.
    step(1'b0, 8'h80, 0, 1'b0);
    step(1'b0, 8'hFF, 0, 1'b0);
    step(1'b1, 8'hC0, 0, 1'b0);
    step(1'b0, 8'h10, 0, 1'b0);

    // Stored random vectors, with mid-cycle junk on inp.
    for (int i = 0; i < 20; i++) stored[i] = 8'($urandom);
    for (int i = 0; i < 20; i++) step(1'b0, stored[i], 0, 1'b1);

    // Random reset pulses interleaved with random operands.
    for (int i = 0; i < 30; i++) step(($urandom_range(0, 7) == 0), 8'($urandom), 0, 1'b0);

    repeat (4) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    monitor_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
